score_display_ctrl: RTL and testbench

- Sequences a shared 10-glyph digit ROM (glyphs 0-9, 16x16 px, 4-bit palette index) to draw a 4-digit decimal score at a fixed screen position.
- Latches a binary score from game logic and commits it only at a vertical-blank line. Converts it to BCD with a multi-cycle shift-add-3 FSM.
- Generates per-pixel ROM addresses from DrawX/DrawY. Emits a registered palette index plus a valid flag for the top-level colour mux.

---
 rtl/score_pkg.sv | 41 ++++
 rtl/score_bin2bcd.sv | 74 +++++++
 rtl/score_display_ctrl.sv | 130 +++++++++++++
 tb/tb_score_display_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// ============================================================================
// Module  : score_pkg
// Purpose : Glyph geometry, score limits, FSM state type and BCD helpers.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package score_pkg;

  localparam int GLYPH_W     = 16;
  localparam int GLYPH_H     = 16;
  localparam int NUM_DIGITS  = 4;
  localparam int GLYPH_WORDS = 256;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } score_state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic [13:0] clamp_score(input logic [13:0] s);
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/score_bin2bcd.sv
// ============================================================================
// Module  : score_bin2bcd
// Purpose : Sequential 14-bit binary to 4-digit BCD converter (shift-add-3).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module score_bin2bcd
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  score_state_t state;
  logic [13:0]  bin_sr;
  logic [15:0]  bcd_sr;
  logic [3:0]   step;
  logic [29:0]  shifted;

  assign shifted = {bcd_adjust(bcd_sr), bin_sr} << 1;
  assign result  = bcd_sr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      step   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            step   <= '0;
            busy   <= 1'b1;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_sr <= shifted[29:14];
          bin_sr <= shifted[13:0];
          step   <= step + 4'd1;
          if (step == 4'd13) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_display_ctrl.sv
// ============================================================================
// Module  : score_display_ctrl
// Purpose : Commits a clamped score at vertical blank, converts it to BCD and
//           drives digit-ROM addresses plus a registered palette/valid pair.
//           Optional macro SCORE_LEADING_ZERO_BLANK_EN hides leading zeros.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module score_display_ctrl
  import score_pkg::*;
#(
  parameter logic [9:0] X0          = 10'd560,
  parameter logic [9:0] Y0          = 10'd16,
  parameter int         SCALE_SH    = 1,
  parameter logic [9:0] COMMIT_LINE = 10'd480
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [13:0] score_in,
  input  logic        score_load,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  output logic [11:0] rom_address,
  input  logic [3:0]  rom_q,
  output logic [3:0]  palette_index,
  output logic        pixel_valid,
  output logic        busy,
  output logic [15:0] score_bcd
);

  localparam int                FIELD_W   = (GLYPH_W * NUM_DIGITS) << SCALE_SH;
  localparam int                FIELD_H   = GLYPH_H << SCALE_SH;
  localparam logic signed [10:0] FIELD_W_S = 11'(FIELD_W);
  localparam logic signed [10:0] FIELD_H_S = 11'(FIELD_H);

  logic [13:0] pending;
  logic        dirty;
  logic        commit;
  logic [13:0] commit_value;
  logic        conv_busy;
  logic        conv_done;
  logic [15:0] conv_result;

  assign commit       = (DrawX == 10'd0) && (DrawY == COMMIT_LINE) && !conv_busy && dirty;
  // A load on the commit cycle itself is fresher than the pending copy.
  assign commit_value = score_load ? clamp_score(score_in) : pending;
  assign busy         = conv_busy;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      pending <= '0;
      dirty   <= 1'b0;
    end else if (commit) begin
      dirty   <= 1'b0;
    end else if (score_load) begin
      pending <= clamp_score(score_in);
      dirty   <= 1'b1;
    end
  end

  score_bin2bcd u_bin2bcd (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .start   (commit),
    .bin     (commit_value),
    .busy    (conv_busy),
    .done    (conv_done),
    .result  (conv_result)
  );

  always_ff @(posedge vga_clk) begin
    if (!reset_n)       score_bcd <= '0;
    else if (conv_done) score_bcd <= conv_result;
  end

  // Signed offsets keep pixels left of / above the field from wrapping inside it.
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic               in_field;
  logic [5:0]         cx;
  logic [3:0]         cy;
  logic [1:0]         slot;
  bcd_digit_t         digit;
  logic               slot_visible;

  assign dx       = $signed({1'b0, DrawX}) - $signed({1'b0, X0});
  assign dy       = $signed({1'b0, DrawY}) - $signed({1'b0, Y0});
  assign in_field = (dx >= 11'sd0) && (dx < FIELD_W_S) && (dy >= 11'sd0) && (dy < FIELD_H_S);
  assign cx       = dx[SCALE_SH +: 6];
  assign cy       = dy[SCALE_SH +: 4];
  assign slot     = cx[5:4];

  always_comb begin
    digit = score_bcd[3:0];
    case (slot)
      2'd0:    digit = score_bcd[15:12];
      2'd1:    digit = score_bcd[11:8];
      2'd2:    digit = score_bcd[7:4];
      default: digit = score_bcd[3:0];
    endcase
  end

  assign rom_address = in_field ? {digit, cy, cx[3:0]} : 12'd0;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic [3:0] lead_vis;
  assign lead_vis[0] = (score_bcd[15:12] != 4'd0);
  assign lead_vis[1] = lead_vis[0] | (score_bcd[11:8] != 4'd0);
  assign lead_vis[2] = lead_vis[1] | (score_bcd[7:4] != 4'd0);
  assign lead_vis[3] = 1'b1;
  assign slot_visible = lead_vis[slot];
`else
  assign slot_visible = 1'b1;
`endif

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      palette_index <= '0;
      pixel_valid   <= 1'b0;
    end else begin
      palette_index <= rom_q;
      pixel_valid   <= in_field & blank & slot_visible & (rom_q != 4'd0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
// ============================================================================
// Module  : tb_score_display_ctrl
// Purpose : Scoreboard bench for score_display_ctrl (directed vectors).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_display_ctrl;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [9:0] COMMIT_LINE = 10'd480;
  localparam int K_ADDR = 0, K_VALID = 1, K_PAL = 2, K_BUSY = 3, K_SCORE = 4;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] score_in = '0;
  logic        score_load = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b0;
  logic [3:0]  rom_q = '0;
  logic [3:0]  rom_val = '0;
  logic [11:0] rom_address;
  logic [3:0]  palette_index;
  logic        pixel_valid;
  logic        busy;
  logic [15:0] score_bcd;

  score_display_ctrl dut (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .score_in      (score_in),
    .score_load    (score_load),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .rom_address   (rom_address),
    .rom_q         (rom_q),
    .palette_index (palette_index),
    .pixel_valid   (pixel_valid),
    .busy          (busy),
    .score_bcd     (score_bcd)
  );

  always #5 vga_clk = ~vga_clk;
  always @(negedge vga_clk) rom_q <= rom_val;   // negedge-clocked ROM stand-in

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct {int due; int kind; logic [15:0] exp; string name;} chk_t;
  typedef struct {logic [15:0] exp; string name;} ev_t;
  chk_t cq[$];
  ev_t  eq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic expect_at(input int due, input int kind, input logic [15:0] e, input string n);
    chk_t c;
    int   i;
    c.due = due; c.kind = kind; c.exp = e; c.name = n;
    i = cq.size();
    while (i > 0 && cq[i-1].due > due) i--;
    cq.insert(i, c);
  endtask

  task automatic expect_commit(input logic [15:0] e, input string n);
    ev_t v;
    v.exp = e; v.name = n;
    eq.push_back(v);
  endtask

  task automatic monitor();
    int          busy_len = 0;
    chk_t        c;
    ev_t         v;
    logic [15:0] act;
    forever begin
      @(negedge vga_clk);
      if (busy === 1'b1) busy_len++;
      else if (busy_len != 0) begin
        if (eq.size() > 0) begin
          v = eq.pop_front();
          check({v.name, "_bcd"}, score_bcd, v.exp);
          check({v.name, "_busy_cycles"}, 16'(busy_len), 16'd15);
        end else if (reset_n !== 1'b0) begin
          total++;
          $display("FAIL unexpected_conversion: got busy for %0d cycles, want none", busy_len);
        end
        busy_len = 0;
      end
      while (cq.size() > 0 && cq[0].due <= cyc) begin
        c = cq.pop_front();
        case (c.kind)
          K_ADDR:  act = {4'b0, rom_address};
          K_VALID: act = {15'b0, pixel_valid};
          K_PAL:   act = {12'b0, palette_index};
          K_BUSY:  act = {15'b0, busy};
          default: act = score_bcd;
        endcase
        if (c.due < cyc) begin
          total++;
          $display("FAIL %s: sampled late at cycle %0d, want cycle %0d", c.name, cyc, c.due);
        end else check(c.name, act, c.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic load(input logic [13:0] v);
    score_in = v; score_load = 1'b1;
    tick();
    score_load = 1'b0;
  endtask

  task automatic go_commit();
    DrawX = 10'd0; DrawY = COMMIT_LINE;
    tick();
    DrawX = 10'd1; DrawY = 10'd481;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || eq.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      total++;
      $display("FAIL %s: got busy=%b with %0d commits outstanding, want idle", name, busy, eq.size());
    end
  endtask

  task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic b,
                           input logic [3:0] q, input logic [11:0] addr, input logic v,
                           input string n);
    DrawX = x; DrawY = y; blank = b; rom_val = q;
    expect_at(cyc,     K_ADDR,  {4'b0, addr}, {n, "_addr"});
    expect_at(cyc + 1, K_VALID, {15'b0, v},   {n, "_valid"});
    expect_at(cyc + 1, K_PAL,   {12'b0, q},   {n, "_pal"});
    tick();
  endtask

  initial begin
    fork monitor(); join_none

    // Reset: a visible opaque pixel is presented so that only reset keeps valid low.
    DrawX = 10'd687; DrawY = 10'd47; blank = 1'b1; rom_val = 4'h9;
    repeat (3) tick();
    expect_at(cyc, K_SCORE, 16'h0000, "rst_bcd");
    expect_at(cyc, K_BUSY,  16'h0000, "rst_busy");
    expect_at(cyc, K_VALID, 16'h0000, "rst_valid");
    expect_at(cyc, K_PAL,   16'h0000, "rst_pal");
    tick();
    reset_n = 1'b1;
    DrawX = 10'd1; DrawY = 10'd200;
    tick();

    // Load 1234; nothing visible until the commit line.
    load(14'd1234);
    expect_at(cyc, K_SCORE, 16'h0000, "t1_pre_commit_bcd");
    repeat (3) tick();
    expect_commit(16'h1234, "t1");
    go_commit();
    repeat (4) tick();
    expect_at(cyc, K_BUSY,  16'h0001, "t1_mid_busy");
    expect_at(cyc, K_SCORE, 16'h0000, "t1_mid_bcd");
    wait_idle("t1_wait");

    // Clamp and last-load-wins.
    load(14'd5);
    load(14'd12345);
    expect_commit(16'h9999, "t2_clamp");
    go_commit();
    wait_idle("t2_wait");

    // Bypass on the commit cycle, then a load during CONVERT waits a frame.
    load(14'd5);
    tick();
    load(14'd77);
    score_in = 14'd300; score_load = 1'b1;
    expect_commit(16'h0300, "t3_bypass");
    go_commit();
    score_load = 1'b0;
    tick();
    load(14'd88);
    wait_idle("t3_wait");
    expect_at(cyc, K_SCORE, 16'h0300, "t3_hold_bcd");
    expect_commit(16'h0088, "t3_next_frame");
    go_commit();
    wait_idle("t3_wait2");
    DrawX = 10'd0; DrawY = COMMIT_LINE;
    expect_at(cyc + 1, K_BUSY, 16'h0000, "t3_clean_no_commit");
    tick();
    DrawX = 10'd1; DrawY = 10'd481;
    tick();

    // Pixel addressing for 0042.
    load(14'd42);
    expect_commit(16'h0042, "t4");
    go_commit();
    wait_idle("t4_wait");
    drive_pix(10'd594, 10'd22, 1'b1, 4'h5, 12'd49,   !LZB, "t4_slot1");
    drive_pix(10'd630, 10'd22, 1'b1, 4'h6, 12'd1075, 1'b1, "t4_slot2");
    drive_pix(10'd630, 10'd22, 1'b1, 4'h0, 12'd1075, 1'b0, "t4_transparent");
    drive_pix(10'd630, 10'd22, 1'b0, 4'h6, 12'd1075, 1'b0, "t4_blanked");
    drive_pix(10'd559, 10'd22, 1'b1, 4'h6, 12'd0,    1'b0, "t4_left_of_field");
    drive_pix(10'd687, 10'd47, 1'b1, 4'h3, 12'd767,  1'b1, "t4_last_pixel");
    drive_pix(10'd688, 10'd47, 1'b1, 4'h3, 12'd0,    1'b0, "t4_right_of_field");
    drive_pix(10'd560, 10'd48, 1'b1, 4'h3, 12'd0,    1'b0, "t4_below_field");
    drive_pix(10'd560, 10'd15, 1'b1, 4'h3, 12'd0,    1'b0, "t4_above_field");
    drive_pix(10'd560, 10'd16, 1'b1, 4'h4, 12'd0,    !LZB, "t4_slot0");

    // Score 0: only the ones digit survives leading-zero blanking.
    load(14'd0);
    expect_commit(16'h0000, "t5");
    go_commit();
    wait_idle("t5_wait");
    drive_pix(10'd630, 10'd22, 1'b1, 4'h6, 12'd51,  !LZB, "t5_slot2");
    drive_pix(10'd687, 10'd47, 1'b1, 4'h3, 12'd255, 1'b1, "t5_slot3");

    // Reset on the 5th CONVERT cycle aborts and clears the pending commit.
    load(14'd7);
    expect_commit(16'h0007, "t6_pre");
    go_commit();
    wait_idle("t6_pre_wait");
    load(14'd1500);
    go_commit();
    DrawX = 10'd687; DrawY = 10'd47; blank = 1'b1; rom_val = 4'h9;
    expect_at(cyc + 1, K_VALID, 16'h0001, "t6_valid_before_abort");
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    expect_at(cyc, K_BUSY,  16'h0000, "t6_abort_busy");
    expect_at(cyc, K_SCORE, 16'h0000, "t6_abort_bcd");
    expect_at(cyc, K_VALID, 16'h0000, "t6_abort_valid");
    tick();
    reset_n = 1'b1;
    tick();
    DrawX = 10'd0; DrawY = COMMIT_LINE;
    expect_at(cyc + 1, K_BUSY, 16'h0000, "t6_no_commit_after_abort");
    tick();
    DrawX = 10'd1; DrawY = 10'd481;
    repeat (20) tick();
    expect_at(cyc, K_SCORE, 16'h0000, "t6_bcd_stays_zero");

    for (int i = 0; i < 5 && cq.size() > 0; i++) tick();
    while (cq.size() > 0) begin
      total++;
      $display("FAIL %s: got no sample, want one at cycle %0d", cq[0].name, cq[0].due);
      void'(cq.pop_front());
    end
    while (eq.size() > 0) begin
      total++;
      $display("FAIL %s: got no commit, want %h", eq[0].name, eq[0].exp);
      void'(eq.pop_front());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
